// File: rtl/lamp.sv
// LAMP: 1 Hz blink on o_led1 and a triangular "breathing" PWM on o_led2.
// Three free-running dividers: half-second toggle, PWM counter, and the
// duty-ramp step divider. Both outputs come straight from flip-flops.
module lamp #(
  parameter int unsigned c_freq     = 12000000,
  parameter int unsigned c_pwm_bits = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_led1,
  output logic o_led2
);

  // Half-second divider geometry
  localparam int unsigned H  = c_freq / 2;
  localparam int unsigned HW = (H > 1) ? $clog2(H) : 1;

  // Ramp step divider geometry; clamped to 1 so a step still exists if the
  // PWM width is large relative to the clock frequency
  localparam int unsigned S_RAW = c_freq >> (c_pwm_bits + 1);
  localparam int unsigned S     = (S_RAW == 0) ? 1 : S_RAW;
  localparam int unsigned SW    = (S > 1) ? $clog2(S) : 1;

  localparam logic [HW-1:0]         H_LAST = HW'(H - 1);
  localparam logic [HW-1:0]         H_ONE  = HW'(1);
  localparam logic [SW-1:0]         S_LAST = SW'(S - 1);
  localparam logic [SW-1:0]         S_ONE  = SW'(1);
  localparam logic [c_pwm_bits-1:0] P_ONE  = c_pwm_bits'(1);
  localparam logic [c_pwm_bits-1:0] D_MAX  = '1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic                  led1_q, led1_d;
  logic [SW-1:0]         s_cnt_q, s_cnt_d;
  logic                  step;
  logic [c_pwm_bits-1:0] p_cnt_q, p_cnt_d;
  logic [c_pwm_bits-1:0] duty_q, duty_d;
  dir_t                  dir_q, dir_d;
  logic                  led2_q, led2_d;

  // Divider next-state: half-second toggle, step pulse, PWM counter and compare
  always_comb begin
    h_cnt_d = h_cnt_q + H_ONE;
    led1_d  = led1_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      led1_d  = ~led1_q;
    end

    step    = (s_cnt_q == S_LAST);
    s_cnt_d = step ? '0 : (s_cnt_q + S_ONE);

    p_cnt_d = p_cnt_q + P_ONE;
    led2_d  = (p_cnt_q < duty_q);
  end

  // Duty ramp next-state: saturate at either end and reverse direction there
  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    if (step) begin
      unique case (dir_q)
        DIR_UP: begin
          if (duty_q == D_MAX) dir_d  = DIR_DOWN;
          else                 duty_d = duty_q + P_ONE;
        end
        DIR_DOWN: begin
          if (duty_q == '0) dir_d  = DIR_UP;
          else              duty_d = duty_q - P_ONE;
        end
        default: dir_d = DIR_UP;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt_q <= '0;
      led1_q  <= 1'b0;
      s_cnt_q <= '0;
      p_cnt_q <= '0;
      duty_q  <= '0;
      dir_q   <= DIR_UP;
      led2_q  <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      led1_q  <= led1_d;
      s_cnt_q <= s_cnt_d;
      p_cnt_q <= p_cnt_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      led2_q  <= led2_d;
    end
  end

  assign o_led1 = led1_q;
  assign o_led2 = led2_q;

endmodule

// File: tb/tb_lamp.sv
// Self-checking bench for lamp with a scaled-down clock so the whole run
// stays short: c_freq=8192, c_pwm_bits=4 -> H=4096, S=256, duty max 15.
module tb_lamp;

  localparam int unsigned C_FREQ = 8192;
  localparam int unsigned C_PWM  = 4;
  localparam int          H      = 4096;
  localparam int          WIN    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic led1, led2;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  lamp #(
    .c_freq    (C_FREQ),
    .c_pwm_bits(C_PWM)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .o_led1(led1),
    .o_led2(led2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_n;
    int led1;
    int duty;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_led1", int'(led1), 0);
      check("rst_led2", int'(led2), 0);
      check("rst_duty", int'(dut.duty_q), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    k   = 0;
  endtask

  task automatic wait_duty(input int target, input int budget);
    int c;
    c = 0;
    while (int'(dut.duty_q) != target && c < budget) begin
      tick();
      c++;
    end
    check("wait_duty", int'(dut.duty_q), target);
  endtask

  task automatic pwm_window(input string name, input int exp_high);
    int hi;
    hi = 0;
    repeat (WIN) begin
      tick();
      if (led2) hi++;
    end
    check(name, hi, exp_high);
  endtask

  initial begin
    int c;
    int toggles;
    logic prev;

    // Edge numbers are counted from the first rising edge after release.
    // Duty after edge k follows floor(k/256) steps of the up/hold/down/hold ramp.
    tbl[0]  = '{1,    0, 0};
    tbl[1]  = '{255,  0, 0};
    tbl[2]  = '{256,  0, 1};
    tbl[3]  = '{511,  0, 1};
    tbl[4]  = '{512,  0, 2};
    tbl[5]  = '{3840, 0, 15};
    tbl[6]  = '{4095, 0, 15};
    tbl[7]  = '{4096, 1, 15};
    tbl[8]  = '{4352, 1, 14};
    tbl[9]  = '{7936, 1, 0};
    tbl[10] = '{8191, 1, 0};
    tbl[11] = '{8192, 0, 0};
    tbl[12] = '{8448, 0, 1};

    // Reset held 10 cycles, then blink timing and ramp checkpoints
    do_reset(10);
    for (int i = 0; i < 13; i++) begin
      while (k < tbl[i].edge_n) tick();
      check("tbl_led1", int'(led1), tbl[i].led1);
      check("tbl_duty", int'(dut.duty_q), tbl[i].duty);
    end

    // PWM high-time over one full 16-cycle window at fixed duties
    wait_duty(8, 20000);
    pwm_window("pwm_duty8", 8);
    wait_duty(15, 20000);
    pwm_window("pwm_duty15", 15);
    wait_duty(0, 20000);
    pwm_window("pwm_duty0", 0);

    // Asynchronous reset between edges while both LEDs are high
    c = 0;
    while (!(led1 && led2) && c < 20000) begin
      tick();
      c++;
    end
    check("pre_arst_high", int'(led1 && led2), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_led1", int'(led1), 0);
    check("arst_led2", int'(led2), 0);
    check("arst_duty", int'(dut.duty_q), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;
    c   = 0;
    while (!led1 && c < 2 * H) begin
      tick();
      c++;
    end
    check("first_toggle_edge", k, H);

    // Five-second run: ten toggles expected
    do_reset(10);
    toggles = 0;
    prev    = led1;
    for (int s = 1; s <= 5; s++) begin
      repeat (C_FREQ) begin
        tick();
        if (led1 != prev) toggles++;
        prev = led1;
      end
      $display("second %0d elapsed, %0d toggles so far", s, toggles);
    end
    check("toggles_5s", toggles, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
